// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: FSM states, access-size codes
// and the writeback select value used by decode.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    ERR
  } lsu_state_e;

  localparam logic [3:0] SZ_BYTE    = 4'b0001;
  localparam logic [3:0] SZ_HALF    = 4'b0011;
  localparam logic [3:0] SZ_WORD    = 4'b1111;
  localparam logic [1:0] LSU_WB_SEL = 2'd2;

  // A legal access has a known size and is naturally aligned to it.
  function automatic logic access_legal(input logic [3:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~offset[0];
      SZ_WORD: return (offset == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_sequencer_if.sv
// Data-memory request/acknowledge bus between the sequencer (master) and memory.
interface lsu_sequencer_if #(
  parameter int XLEN = 32
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and extract/extend for loads; purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [3:0]  size,
  input  logic        us,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [4:0]  shift;
  logic [31:0] rsh;

  assign shift = {offset, 3'b000};
  assign be    = size << offset;
  assign wdata = st_data << shift;
  assign rsh   = rdata >> shift;

  always_comb begin
    case (size)
      SZ_BYTE: ld_data = {{24{~us & rsh[7]}},  rsh[7:0]};
      SZ_HALF: ld_data = {{16{~us & rsh[15]}}, rsh[15:0]};
      default: ld_data = rsh;
    endcase
  end

endmodule

// File: rtl/lsu_sequencer.sv
// Runs one data-memory access per load/store, stalling the pipeline until the
// memory acknowledges, times out, or the access is rejected as misaligned.
module lsu_sequencer
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_vld,
  input  logic            is_store,
  input  logic [3:0]      mem_wrnum,
  input  logic            mem_us,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] st_data,
  output logic            stall,
  output logic            ld_vld,
  output logic [XLEN-1:0] ld_data,
  output logic            misalign_err,
  output logic            bus_err,
  lsu_sequencer_if.master dmem
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1) + 1;

  lsu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            capture, rdata_en;

  logic            we_q, us_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic [3:0]      be_q, size_q;
  logic [1:0]      off_q;

  logic [3:0]      store_be;
  logic [XLEN-1:0] store_wdata, ld_aligned;
  logic [XLEN-1:0] unused_st_ld, unused_ld_wdata;
  logic [3:0]      unused_ld_be;

  lsu_align u_store_align (
    .offset (addr[1:0]),
    .size   (mem_wrnum),
    .us     (1'b0),
    .st_data(st_data),
    .rdata  ('0),
    .be     (store_be),
    .wdata  (store_wdata),
    .ld_data(unused_st_ld)
  );

  lsu_align u_load_align (
    .offset (off_q),
    .size   (size_q),
    .us     (us_q),
    .st_data('0),
    .rdata  (rdata_q),
    .be     (unused_ld_be),
    .wdata  (unused_ld_wdata),
    .ld_data(ld_aligned)
  );

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    capture      = 1'b0;
    rdata_en     = 1'b0;
    stall        = 1'b0;
    misalign_err = 1'b0;
    bus_err      = 1'b0;
    ld_vld       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_vld) begin
          if (access_legal(mem_wrnum, addr[1:0])) begin
            stall   = 1'b1;
            capture = 1'b1;
            cnt_d   = '0;
            state_d = ACCESS;
          end else begin
            misalign_err = 1'b1;
          end
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (dmem.dmem_ack) begin
          rdata_en = ~we_q;
          state_d  = DONE;
        end else if (TIMEOUT_CYC != 0) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(TIMEOUT_CYC)) state_d = ERR;
        end
      end
      DONE: begin
        ld_vld  = ~we_q;
        state_d = IDLE;
      end
      ERR: begin
        bus_err = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The IDLE-cycle outputs follow req_vld combinationally; hold them low while in reset.
    if (!rst_n) begin
      stall        = 1'b0;
      misalign_err = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      us_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      size_q  <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        we_q    <= is_store;
        us_q    <= mem_us;
        addr_q  <= {addr[XLEN-1:2], 2'b00};
        wdata_q <= store_wdata;
        be_q    <= store_be;
        size_q  <= mem_wrnum;
        off_q   <= addr[1:0];
      end
      if (rdata_en) rdata_q <= dmem.dmem_rdata;
    end
  end

  assign dmem.dmem_req   = (state_q == ACCESS);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;
  assign ld_data         = ld_vld ? ld_aligned : '0;

endmodule
